// File: rtl/imm_pkg.sv
// Shared immediate-encoding definitions: ImmSrc codes, encoder FSM states,
// result payload and the direct (non-rotated) encode function.
package imm_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INSTR_W = 24;
  localparam int unsigned ROT_W   = 4;

  // ImmSrc codes shared with the extender and control decode
  localparam logic [1:0] IMM8    = 2'b00;
  localparam logic [1:0] IMM12   = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_ROT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } imm_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               fits;
  } imm_result_t;

  // Single-cycle encode for imm8, imm12 and branch modes; no-fit yields all zero
  function automatic imm_result_t encode_fixed(input logic [DATA_W-1:0] data,
                                               input logic [1:0]        src);
    imm_result_t res;
    res = '0;
    case (src)
      IMM8: begin
        if (data[31:8] == 24'h0) begin
          res.instr = {16'h0, data[7:0]};
          res.fits  = 1'b1;
        end
      end
      IMM12: begin
        if (data[31:12] == 20'h0) begin
          res.instr = {12'h0, data[11:0]};
          res.fits  = 1'b1;
        end
      end
      IMM_BR: begin
        // word aligned and bits above the 26-bit signed range are pure sign copies
        if ((data[1:0] == 2'b00) &&
            ((data[31:25] == 7'h00) || (data[31:25] == 7'h7F))) begin
          res.instr = data[25:2];
          res.fits  = 1'b1;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder.
// master: requester (drives request and out_ready); slave: encoder.
interface imm_encoder_if;
  import imm_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   Data_in;
  logic [1:0]          ImmSrc;
  logic                out_valid;
  logic                out_ready;
  logic [INSTR_W-1:0]  Instr;
  logic                fits;

  modport master (
    output in_valid, Data_in, ImmSrc, out_ready,
    input  in_ready, out_valid, Instr, fits
  );

  modport slave (
    input  in_valid, Data_in, ImmSrc, out_ready,
    output in_ready, out_valid, Instr, fits
  );

endinterface

// File: rtl/imm_rot_check.sv
// Combinational test of one rotation candidate for the rotated-imm8 form.
// value : constant being encoded
// r     : rotate field candidate (rotation amount 2*r)
// hit   : rotate-left(value, 2*r) fits in 8 bits
// imm8  : low byte of the rotated value
module imm_rot_check
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [ROT_W-1:0]  r,
  output logic              hit,
  output logic [7:0]        imm8
);

  logic [4:0]        amt;
  logic [DATA_W-1:0] t;

  // Left-rotate here undoes the extender's right-rotate; a 32-bit shift yields 0 when r==0
  always_comb begin
    amt  = {r, 1'b0};
    t    = (value << amt) | (value >> (6'd32 - 6'(amt)));
    hit  = (t[31:8] == 24'h0);
    imm8 = t[7:0];
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: maps a 32-bit constant/offset and ImmSrc mode to the
// 24-bit instruction immediate field, with a fits flag.
// clk   : clock, rising edge
// rst_n : synchronous active-low reset
// bus   : imm_encoder_if.slave (valid/ready request in, valid/ready result out)
module imm_encoder
  import imm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  imm_encoder_if.slave  bus
);

  imm_state_t          state;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          src_q;
  logic [ROT_W-1:0]    r_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [INSTR_W-1:0]  instr_q;
  logic                fits_q;

  imm_result_t         fixed_res;
  logic                rot_hit;
  logic [7:0]          rot_imm8;

  // Direct modes resolve from the live request in the acceptance cycle
  assign fixed_res = encode_fixed(bus.Data_in, bus.ImmSrc);

  imm_rot_check u_rot (
    .value (data_q),
    .r     (r_q),
    .hit   (rot_hit),
    .imm8  (rot_imm8)
  );

  // Control FSM, rotation counter, input latches and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      data_q      <= '0;
      src_q       <= IMM8;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      fits_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.Data_in;
            src_q      <= bus.ImmSrc;
            in_ready_q <= 1'b0;
            if (bus.ImmSrc == IMM_ROT) begin
              r_q   <= '0;
              state <= ST_SEARCH;
            end else begin
              instr_q     <= fixed_res.instr;
              fits_q      <= fixed_res.fits;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_SEARCH: begin
          // Counter walks upward, so the first hit is the lowest rotate field
          if ((src_q == IMM_ROT) && rot_hit) begin
            instr_q     <= {12'h0, r_q, rot_imm8};
            fits_q      <= 1'b1;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else if ((src_q != IMM_ROT) || (r_q == 4'd15)) begin
            instr_q     <= '0;
            fits_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end else begin
            r_q <= r_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Instr     = instr_q;
  assign bus.fits      = fits_q;

endmodule
